// File: rtl/sensor_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sensor_scheduler                                                         |
// | Round-robin sequencer that keeps only one of SR04 / DHT11 measuring.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sensor_scheduler #(
   parameter int CLK_PER_MS      = 100_000,
   parameter int SR04_PERIOD_MS  = 100,
   parameter int DHT11_PERIOD_MS = 2000,
   parameter int SR04_TMO_MS     = 30,
   parameter int DHT11_TMO_MS    = 50,
   parameter int GUARD_MS        = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sel_set_4,
   input  logic       auto_en,
   input  logic       btn_r,
   input  logic       btn_l,
   input  logic       sr04_done,
   input  logic       dht11_done,
   output logic       o_sr04_start,
   output logic       o_dht11_start,
   output logic       o_busy,
   output logic [1:0] o_active,
   output logic       o_sr04_err,
   output logic       o_dht11_err
);

   localparam int c_PRESC_W  = (CLK_PER_MS > 1)      ? $clog2(CLK_PER_MS)      : 1;
   localparam int c_SR_PER_W = (SR04_PERIOD_MS > 1)  ? $clog2(SR04_PERIOD_MS)  : 1;
   localparam int c_DH_PER_W = (DHT11_PERIOD_MS > 1) ? $clog2(DHT11_PERIOD_MS) : 1;
   localparam int c_TMR_MAX  = (SR04_TMO_MS > DHT11_TMO_MS) ?
                               ((SR04_TMO_MS > GUARD_MS) ? SR04_TMO_MS : GUARD_MS) :
                               ((DHT11_TMO_MS > GUARD_MS) ? DHT11_TMO_MS : GUARD_MS);
   localparam int c_TMR_W    = $clog2(c_TMR_MAX + 1);

   localparam logic [c_PRESC_W-1:0]  c_PRESC_LAST   = c_PRESC_W'(CLK_PER_MS - 1);
   localparam logic [c_SR_PER_W-1:0] c_SR_PER_LAST  = c_SR_PER_W'(SR04_PERIOD_MS - 1);
   localparam logic [c_DH_PER_W-1:0] c_DH_PER_LAST  = c_DH_PER_W'(DHT11_PERIOD_MS - 1);
   localparam logic [c_TMR_W-1:0]    c_SR_TMO_LAST  = c_TMR_W'(SR04_TMO_MS - 1);
   localparam logic [c_TMR_W-1:0]    c_DH_TMO_LAST  = c_TMR_W'(DHT11_TMO_MS - 1);
   localparam logic [c_TMR_W-1:0]    c_GUARD_LAST   = c_TMR_W'(GUARD_MS - 1);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_SR04_WAIT  = 2'd1,
      S_DHT11_WAIT = 2'd2,
      S_GUARD      = 2'd3
   } state_t;

   state_t                r_state;
   logic [c_PRESC_W-1:0]  r_presc;
   logic [c_SR_PER_W-1:0] r_sr_per;
   logic [c_DH_PER_W-1:0] r_dh_per;
   logic [c_TMR_W-1:0]    r_tmr;
   logic                  r_sr04_pend;
   logic                  r_dht11_pend;
   logic                  r_last_sr04;

   logic w_tick;
   logic w_sr_expire;
   logic w_dh_expire;
   logic w_sr04_req;
   logic w_dht11_req;
   logic w_grant_sr04;
   logic w_grant_dht11;

   assign w_tick      = (r_presc == c_PRESC_LAST);
   assign w_sr_expire = auto_en & w_tick & (r_sr_per == c_SR_PER_LAST);
   assign w_dh_expire = auto_en & w_tick & (r_dh_per == c_DH_PER_LAST);
   assign w_sr04_req  = (btn_l & (sel_set_4 == 2'b10)) | w_sr_expire;
   assign w_dht11_req = (btn_r & (sel_set_4 == 2'b11)) | w_dh_expire;

   // With both pending, the sensor not served last goes first.
   assign w_grant_sr04  = (r_state == S_IDLE) & r_sr04_pend  & (~r_dht11_pend | ~r_last_sr04);
   assign w_grant_dht11 = (r_state == S_IDLE) & r_dht11_pend & (~r_sr04_pend  |  r_last_sr04);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr_per <= '0;
         r_dh_per <= '0;
      end else if (!auto_en) begin
         r_sr_per <= '0;
         r_dh_per <= '0;
      end else if (w_tick) begin
         r_sr_per <= w_sr_expire ? '0 : r_sr_per + c_SR_PER_W'(1);
         r_dh_per <= w_dh_expire ? '0 : r_dh_per + c_DH_PER_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_tmr         <= '0;
         r_sr04_pend   <= 1'b0;
         r_dht11_pend  <= 1'b0;
         r_last_sr04   <= 1'b0;
         o_sr04_start  <= 1'b0;
         o_dht11_start <= 1'b0;
         o_busy        <= 1'b0;
         o_active      <= 2'b00;
         o_sr04_err    <= 1'b0;
         o_dht11_err   <= 1'b0;
      end else begin
         o_sr04_start  <= 1'b0;
         o_dht11_start <= 1'b0;
         // A request in the grant cycle keeps its flag set.
         r_sr04_pend   <= w_sr04_req  | (r_sr04_pend  & ~w_grant_sr04);
         r_dht11_pend  <= w_dht11_req | (r_dht11_pend & ~w_grant_dht11);

         case (r_state)
            S_IDLE: begin
               if (w_grant_sr04) begin
                  r_state      <= S_SR04_WAIT;
                  r_tmr        <= '0;
                  r_last_sr04  <= 1'b1;
                  o_sr04_start <= 1'b1;
                  o_busy       <= 1'b1;
                  o_active     <= 2'b01;
               end else if (w_grant_dht11) begin
                  r_state       <= S_DHT11_WAIT;
                  r_tmr         <= '0;
                  r_last_sr04   <= 1'b0;
                  o_dht11_start <= 1'b1;
                  o_busy        <= 1'b1;
                  o_active      <= 2'b10;
               end
            end

            S_SR04_WAIT: begin
               if (sr04_done) begin
                  r_state    <= S_GUARD;
                  r_tmr      <= '0;
                  o_active   <= 2'b00;
                  o_sr04_err <= 1'b0;
               end else if (w_tick) begin
                  if (r_tmr == c_SR_TMO_LAST) begin
                     r_state    <= S_GUARD;
                     r_tmr      <= '0;
                     o_active   <= 2'b00;
                     o_sr04_err <= 1'b1;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end
            end

            S_DHT11_WAIT: begin
               if (dht11_done) begin
                  r_state     <= S_GUARD;
                  r_tmr       <= '0;
                  o_active    <= 2'b00;
                  o_dht11_err <= 1'b0;
               end else if (w_tick) begin
                  if (r_tmr == c_DH_TMO_LAST) begin
                     r_state     <= S_GUARD;
                     r_tmr       <= '0;
                     o_active    <= 2'b00;
                     o_dht11_err <= 1'b1;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end
            end

            S_GUARD: begin
               if (w_tick) begin
                  if (r_tmr == c_GUARD_LAST) begin
                     r_state <= S_IDLE;
                     r_tmr   <= '0;
                     o_busy  <= 1'b0;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_tmr    <= '0;
               o_busy   <= 1'b0;
               o_active <= 2'b00;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sensor_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sensor_scheduler                                                      |
// | Scoreboard bench with a tick-level reference model of the scheduler.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sensor_scheduler;

   localparam int CLK = 10;
   localparam int SRP = 5;
   localparam int DHP = 8;
   localparam int SRT = 3;
   localparam int DHT = 4;
   localparam int GRD = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] sel_set_4 = 2'b00;
   logic       auto_en = 1'b0;
   logic       btn_r = 1'b0;
   logic       btn_l = 1'b0;
   logic       sr04_done = 1'b0;
   logic       dht11_done = 1'b0;
   logic       o_sr04_start;
   logic       o_dht11_start;
   logic       o_busy;
   logic [1:0] o_active;
   logic       o_sr04_err;
   logic       o_dht11_err;

   sensor_scheduler #(
      .CLK_PER_MS(CLK), .SR04_PERIOD_MS(SRP), .DHT11_PERIOD_MS(DHP),
      .SR04_TMO_MS(SRT), .DHT11_TMO_MS(DHT), .GUARD_MS(GRD)
   ) dut (
      .clk(clk), .reset(reset), .sel_set_4(sel_set_4), .auto_en(auto_en),
      .btn_r(btn_r), .btn_l(btn_l), .sr04_done(sr04_done), .dht11_done(dht11_done),
      .o_sr04_start(o_sr04_start), .o_dht11_start(o_dht11_start), .o_busy(o_busy),
      .o_active(o_active), .o_sr04_err(o_sr04_err), .o_dht11_err(o_dht11_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: phase 0 idle, 1 SR04 measuring, 2 DHT11 measuring, 3 guard gap.
   typedef struct { int sensor; int at; } ev_t;
   ev_t exp_q[$];
   int  m_edges = 0, m_sr_ticks = 0, m_dh_ticks = 0, m_phase = 0, m_left = 0;
   bit  m_sr_pend = 0, m_dh_pend = 0, m_last_sr = 0, m_sr_err = 0, m_dh_err = 0;

   task automatic model_step();
      bit tick, exp_sr, exp_dh, req_sr, req_dh, g_sr, g_dh;
      tick = ((m_edges % CLK) == CLK - 1);
      m_edges++;
      exp_sr = 0;
      exp_dh = 0;
      if (!auto_en) begin
         m_sr_ticks = 0;
         m_dh_ticks = 0;
      end else if (tick) begin
         m_sr_ticks++;
         m_dh_ticks++;
         if (m_sr_ticks == SRP) begin exp_sr = 1; m_sr_ticks = 0; end
         if (m_dh_ticks == DHP) begin exp_dh = 1; m_dh_ticks = 0; end
      end
      req_sr = (btn_l && sel_set_4 == 2'b10) || exp_sr;
      req_dh = (btn_r && sel_set_4 == 2'b11) || exp_dh;
      g_sr = 0;
      g_dh = 0;
      case (m_phase)
         0: begin
            if (m_sr_pend && m_dh_pend) begin
               if (m_last_sr) g_dh = 1; else g_sr = 1;
            end else if (m_sr_pend) g_sr = 1;
            else if (m_dh_pend) g_dh = 1;
            if (g_sr) begin
               m_phase = 1; m_left = SRT; m_last_sr = 1;
               exp_q.push_back('{0, cyc + 1});
            end else if (g_dh) begin
               m_phase = 2; m_left = DHT; m_last_sr = 0;
               exp_q.push_back('{1, cyc + 1});
            end
         end
         1: begin
            if (sr04_done) begin
               m_sr_err = 0; m_phase = 3; m_left = GRD;
            end else if (tick) begin
               m_left--;
               if (m_left == 0) begin m_sr_err = 1; m_phase = 3; m_left = GRD; end
            end
         end
         2: begin
            if (dht11_done) begin
               m_dh_err = 0; m_phase = 3; m_left = GRD;
            end else if (tick) begin
               m_left--;
               if (m_left == 0) begin m_dh_err = 1; m_phase = 3; m_left = GRD; end
            end
         end
         default: begin
            if (tick) begin
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
         end
      endcase
      m_sr_pend = req_sr || (m_sr_pend && !g_sr);
      m_dh_pend = req_dh || (m_dh_pend && !g_dh);
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_edges = 0; m_sr_ticks = 0; m_dh_ticks = 0; m_phase = 0; m_left = 0;
            m_sr_pend = 0; m_dh_pend = 0; m_last_sr = 0; m_sr_err = 0; m_dh_err = 0;
            exp_q.delete();
         end else begin
            model_step();
         end
      end
   end

   // Monitor: pops expected starts and compares the status outputs every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            logic [4:0] st_req;
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
               n_cmp++; n_bad++;
               $display("FAIL start_missing: got no start, required sensor %0d at cycle %0d",
                        exp_q[0].sensor, exp_q[0].at);
               void'(exp_q.pop_front());
            end
            if (o_sr04_start || o_dht11_start) begin
               int s;
               s = o_sr04_start ? 0 : 1;
               n_cmp++;
               if (o_sr04_start && o_dht11_start) begin
                  n_bad++;
                  $display("FAIL start_overlap: got both starts at cycle %0d, required one", cyc);
               end else if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL start_unexpected: got sensor %0d at cycle %0d, required none", s, cyc);
               end else if (exp_q[0].sensor != s || exp_q[0].at != cyc) begin
                  n_bad++;
                  $display("FAIL start_seq: got sensor %0d at %0d, required sensor %0d at %0d",
                           s, cyc, exp_q[0].sensor, exp_q[0].at);
                  void'(exp_q.pop_front());
               end else begin
                  void'(exp_q.pop_front());
               end
            end
            st_req = {m_phase != 0, m_phase == 2, m_phase == 1, m_sr_err, m_dh_err};
            n_cmp++;
            if ({o_busy, o_active, o_sr04_err, o_dht11_err} !== st_req) begin
               n_bad++;
               $display("FAIL status @%0d: got busy/active/errs %b required %b", cyc,
                        {o_busy, o_active, o_sr04_err, o_dht11_err}, st_req);
            end
         end
      end
   end

   // Sensor responder: returns done a configurable number of cycles after each start.
   int sr_cd = 0, dh_cd = 0, resp_delay = 5;
   bit resp_sr_en = 1, resp_dh_en = 1, rnd_resp = 0;
   initial begin
      forever begin
         @(negedge clk);
         sr04_done = 0;
         dht11_done = 0;
         if (sr_cd > 0) begin sr_cd--; if (sr_cd == 0) sr04_done = 1; end
         if (dh_cd > 0) begin dh_cd--; if (dh_cd == 0) dht11_done = 1; end
         if (o_sr04_start && resp_sr_en)
            sr_cd = rnd_resp ? int'($urandom_range(1, 50)) : resp_delay;
         if (o_dht11_start && resp_dh_en)
            dh_cd = rnd_resp ? int'($urandom_range(1, 50)) : resp_delay;
      end
   end

   task automatic check(string nm, logic [7:0] act, logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(bit left, logic [1:0] sel);
      @(negedge clk);
      sel_set_4 = sel;
      if (left) btn_l = 1; else btn_r = 1;
      @(negedge clk);
      btn_l = 0;
      btn_r = 0;
   endtask

   task automatic wait_active(string nm, logic [1:0] a, int budget);
      int k = 0;
      while (o_active !== a && k < budget) begin @(negedge clk); k++; end
      n_cmp++;
      if (o_active !== a) begin
         n_bad++;
         $display("FAIL %s: timeout, got o_active %b required %b", nm, o_active, a);
      end
   endtask

   task automatic wait_idle(string nm, int budget);
      int k = 0;
      while (o_busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
      n_cmp++;
      if (o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: timeout, got o_busy %b required 0", nm, o_busy);
      end
   endtask

   initial begin
      wait_cycles(3);
      check("reset_outputs", {o_sr04_start, o_dht11_start, o_busy, o_active, o_sr04_err, o_dht11_err}, 8'h00);
      reset = 0;

      // Quiet idle.
      wait_cycles(200);
      check("idle_busy", {7'd0, o_busy}, 8'h00);
      check("idle_active", {6'd0, o_active}, 8'h00);

      // Single SR04 button request with done 20 cycles after start.
      resp_delay = 20;
      pulse(1, 2'b10);
      wait_active("sr04_grant", 2'b01, 10);
      wait_idle("sr04_finish", 60);

      // DHT11 and SR04 queued while SR04 busy: DHT11 must go first.
      pulse(1, 2'b10);
      wait_active("sr04_busy", 2'b01, 10);
      pulse(0, 2'b11);
      pulse(1, 2'b10);
      wait_active("dht_first", 2'b10, 100);
      wait_active("sr04_after", 2'b01, 100);
      wait_idle("queue_drain", 100);

      // DHT11 timeout, then a good DHT11 measurement clears the flag.
      resp_dh_en = 0;
      pulse(0, 2'b11);
      wait_active("dht_tmo_grant", 2'b10, 10);
      wait_idle("dht_tmo_idle", 100);
      check("dht_err_set", {7'd0, o_dht11_err}, 8'h01);
      resp_dh_en = 1;
      resp_delay = 5;
      pulse(0, 2'b11);
      wait_active("dht_ok_grant", 2'b10, 10);
      wait_idle("dht_ok_idle", 100);
      check("dht_err_clr", {7'd0, o_dht11_err}, 8'h00);

      // Periodic auto-refresh.
      sel_set_4 = 2'b00;
      auto_en = 1;
      wait_cycles(400);
      auto_en = 0;
      wait_idle("auto_drain", 100);

      // Randomized buttons, modes, auto toggles and response delays.
      rnd_resp = 1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         sel_set_4 = 2'($urandom_range(0, 3));
         btn_l = ($urandom_range(0, 15) == 0);
         btn_r = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      end
      @(negedge clk);
      btn_l = 0;
      btn_r = 0;
      auto_en = 0;
      rnd_resp = 0;
      wait_cycles(150);
      wait_idle("random_drain", 200);

      // Asynchronous reset during SR04 measurement; the late done must be ignored.
      resp_delay = 20;
      pulse(1, 2'b10);
      wait_active("pre_reset_grant", 2'b01, 10);
      wait_cycles(3);
      #2 reset = 1;
      #1 check("async_reset", {o_sr04_start, o_dht11_start, o_busy, o_active, o_sr04_err, o_dht11_err}, 8'h00);
      @(negedge clk);
      reset = 0;
      wait_cycles(60);
      check("late_done_busy", {7'd0, o_busy}, 8'h00);

      wait_cycles(5);
      check("queue_empty", 8'(exp_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
